// File: rtl/apb_stream_regs.sv
// apb_stream_regs: APB4 slave register block. It fronts NUM_CH valid/ready
// stream channels, each with a TX holding register, an RX pop port, sticky
// errors and a CFG register. It also holds the global ID, SCRATCH and GPIO
// registers. Blocking TX/RX accesses insert wait states, bounded by TIMEOUT.
module apb_stream_regs #(
  parameter int          NUM_CH   = 2,
  parameter int          DATA_W   = 32,
  parameter int          ADDR_W   = 12,
  parameter int          CFG_W    = 8,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ID_VALUE = 32'h5242_0002
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       psel,
  input  logic                       penable,
  input  logic [ADDR_W-1:0]          paddr,
  input  logic                       pwrite,
  input  logic [31:0]                pwdata,
  input  logic [3:0]                 pstrb,
  output logic [31:0]                prdata,
  output logic                       pready,
  output logic                       pslverr,
  output logic [7:0]                 gpio_out,
  output logic [NUM_CH*DATA_W-1:0]   tx_data,
  output logic [NUM_CH-1:0]          tx_valid,
  input  logic [NUM_CH-1:0]          tx_ready,
  input  logic [NUM_CH*DATA_W-1:0]   rx_data,
  input  logic [NUM_CH-1:0]          rx_valid,
  output logic [NUM_CH-1:0]          rx_ready,
  output logic [NUM_CH*CFG_W-1:0]    cfg,
  output logic [NUM_CH-1:0]          cfg_wr
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int HW = ADDR_W - 5;

  typedef enum logic [2:0] {
    R_NONE, R_ID, R_SCRATCH, R_GPIO, R_TX, R_RX, R_STATUS, R_CFG
  } reg_e;

  logic [31:0]              scratch_q, scratch_d;
  logic [7:0]               gpio_q, gpio_d;
  logic [NUM_CH*DATA_W-1:0] tx_data_q, tx_data_d;
  logic [NUM_CH-1:0]        tx_valid_q, tx_valid_d;
  logic [NUM_CH-1:0]        blk_q, blk_d;
  logic [NUM_CH-1:0]        cfg_wr_q, cfg_wr_d;
  logic [NUM_CH-1:0]        tx_err_q, tx_err_d;
  logic [NUM_CH-1:0]        rx_err_q, rx_err_d;
  logic [NUM_CH*CFG_W-1:0]  cfg_q, cfg_d;
  logic [15:0]              wait_q, wait_d;

  logic          acc;
  logic [HW-1:0] region_idx;
  logic [HW-1:0] ch_off;
  logic [CW-1:0] ch;
  reg_e          sel;
  logic [31:0]   cur_cfg;
  logic [31:0]   cfg_merged;
  logic          timed_out;
  int            tx_lo;
  int            cfg_lo;
  logic          unused_addr_lsb;

  // Reset also masks the access phase so pready drops the moment reset asserts
  assign acc             = psel & penable & reset_n;
  assign unused_addr_lsb = ^paddr[1:0];

  // Byte-lane merge used by the strobed registers
  function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    end
    return res;
  endfunction

  // Address decode: globals live below 0x100, channels in 0x20-byte windows above
  always_comb begin
    region_idx = paddr[ADDR_W-1:5];
    ch_off     = region_idx - HW'(8);
    ch         = ch_off[CW-1:0];
    sel        = R_NONE;
    if (paddr[ADDR_W-1:8] == '0) begin
      case (paddr[7:2])
        6'd0:    sel = R_ID;
        6'd1:    sel = R_SCRATCH;
        6'd2:    sel = R_GPIO;
        default: sel = R_NONE;
      endcase
    end else if ((ch_off < HW'(NUM_CH)) && !paddr[4]) begin
      case (paddr[3:2])
        2'd0:    sel = R_TX;
        2'd1:    sel = R_RX;
        2'd2:    sel = R_STATUS;
        default: sel = R_CFG;
      endcase
    end
  end

  // Access handling: completion/wait/error response and next register state
  always_comb begin
    scratch_d  = scratch_q;
    gpio_d     = gpio_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q & ~tx_ready;  // handshake drains the holding register
    blk_d      = blk_q;
    cfg_d      = cfg_q;
    tx_err_d   = tx_err_q;
    rx_err_d   = rx_err_q;
    cfg_wr_d   = '0;
    wait_d     = '0;                      // any non-stalled cycle clears the counter
    pready     = 1'b0;
    pslverr    = 1'b0;
    prdata     = '0;
    rx_ready   = '0;
    timed_out  = (wait_q >= 16'(TIMEOUT));
    tx_lo      = int'(ch) * DATA_W;
    cfg_lo     = int'(ch) * CFG_W;
    cur_cfg    = '0;
    cur_cfg[CFG_W-1:0] = cfg_q[cfg_lo +: CFG_W];
    cur_cfg[31]        = blk_q[ch];
    cfg_merged = strb_merge(cur_cfg, pwdata, pstrb);

    if (acc) begin
      pready = 1'b1;
      case (sel)
        R_ID: begin
          if (pwrite) pslverr = 1'b1;
          else        prdata  = ID_VALUE;
        end
        R_SCRATCH: begin
          if (pwrite) scratch_d = strb_merge(scratch_q, pwdata, pstrb);
          else        prdata    = scratch_q;
        end
        R_GPIO: begin
          if (pwrite) begin
            if (pstrb[0]) gpio_d = pwdata[7:0];
          end else begin
            prdata = {24'h0, gpio_q};
          end
        end
        R_TX: begin
          if (pwrite) begin
            if (!tx_valid_q[ch]) begin
              tx_data_d[tx_lo +: DATA_W] = pwdata[DATA_W-1:0];
              tx_valid_d[ch]             = 1'b1;
            end else if (!blk_q[ch] || timed_out) begin
              pslverr      = 1'b1;
              tx_err_d[ch] = 1'b1;
            end else begin
              pready = 1'b0;
              wait_d = wait_q + 16'd1;
            end
          end
        end
        R_RX: begin
          if (pwrite) begin
            pslverr = 1'b1;
          end else if (rx_valid[ch]) begin
            prdata[DATA_W-1:0] = rx_data[tx_lo +: DATA_W];
            rx_ready[ch]       = 1'b1;
          end else if (!blk_q[ch] || timed_out) begin
            pslverr      = 1'b1;
            rx_err_d[ch] = 1'b1;
          end else begin
            pready = 1'b0;
            wait_d = wait_q + 16'd1;
          end
        end
        R_STATUS: begin
          if (pwrite) begin
            if (pwdata[2]) tx_err_d[ch] = 1'b0;
            if (pwdata[3]) rx_err_d[ch] = 1'b0;
          end else begin
            prdata = {28'h0, rx_err_q[ch], tx_err_q[ch], rx_valid[ch], tx_valid_q[ch]};
          end
        end
        R_CFG: begin
          if (pwrite) begin
            cfg_d[cfg_lo +: CFG_W] = cfg_merged[CFG_W-1:0];
            blk_d[ch]              = cfg_merged[31];
            cfg_wr_d[ch]           = 1'b1;
          end else begin
            prdata = cur_cfg;
          end
        end
        default: pslverr = 1'b1;
      endcase
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scratch_q  <= '0;
      gpio_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= '0;
      blk_q      <= '1;
      cfg_q      <= '0;
      cfg_wr_q   <= '0;
      tx_err_q   <= '0;
      rx_err_q   <= '0;
      wait_q     <= '0;
    end else begin
      scratch_q  <= scratch_d;
      gpio_q     <= gpio_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      blk_q      <= blk_d;
      cfg_q      <= cfg_d;
      cfg_wr_q   <= cfg_wr_d;
      tx_err_q   <= tx_err_d;
      rx_err_q   <= rx_err_d;
      wait_q     <= wait_d;
    end
  end

  assign gpio_out = gpio_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign cfg      = cfg_q;
  assign cfg_wr   = cfg_wr_q;

endmodule

// File: tb/tb_apb_stream_regs.sv
// tb_apb_stream_regs: directed and randomized APB traffic against
// apb_stream_regs, with a per-cycle behavioural model of the register block.
module tb_apb_stream_regs;

  localparam int          NUM_CH   = 2;
  localparam int          DATA_W   = 32;
  localparam int          ADDR_W   = 12;
  localparam int          CFG_W    = 8;
  localparam int          TIMEOUT  = 8;
  localparam logic [31:0] ID_VALUE = 32'h5242_0002;

  localparam int K_NONE = 0, K_ID = 1, K_SCR = 2, K_GPIO = 3;
  localparam int K_TX = 4, K_RX = 5, K_ST = 6, K_CFG = 7;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic                     psel, penable, pwrite;
  logic [ADDR_W-1:0]        paddr;
  logic [31:0]              pwdata;
  logic [3:0]               pstrb;
  logic [31:0]              prdata;
  logic                     pready, pslverr;
  logic [7:0]               gpio_out;
  logic [NUM_CH*DATA_W-1:0] tx_data;
  logic [NUM_CH-1:0]        tx_valid, tx_ready;
  logic [NUM_CH*DATA_W-1:0] rx_data;
  logic [NUM_CH-1:0]        rx_valid, rx_ready;
  logic [NUM_CH*CFG_W-1:0]  cfg;
  logic [NUM_CH-1:0]        cfg_wr;

  int total = 0;
  int bad   = 0;
  bit rand_mode = 1'b0;
  int pop0_cnt = 0;
  int cfgwr1_cnt = 0;

  // Behavioural model state
  logic [31:0] m_scratch;
  logic [7:0]  m_gpio;
  logic [31:0] m_txd   [NUM_CH];
  bit          m_txv   [NUM_CH];
  logic [7:0]  m_cfg   [NUM_CH];
  bit          m_blk   [NUM_CH];
  bit          m_txe   [NUM_CH];
  bit          m_rxe   [NUM_CH];
  bit          m_cfgwr [NUM_CH];
  int          m_wait;

  apb_stream_regs #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CFG_W(CFG_W),
    .TIMEOUT(TIMEOUT), .ID_VALUE(ID_VALUE)
  ) dut (
    .clk(clk), .reset_n(reset_n), .psel(psel), .penable(penable),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata), .pready(pready), .pslverr(pslverr), .gpio_out(gpio_out),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .cfg(cfg), .cfg_wr(cfg_wr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] bytes_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  // Map a byte address onto a register kind and channel number
  function automatic void decode(input logic [ADDR_W-1:0] a_in, output int kind, output int c);
    int a, off;
    a    = int'(a_in) & 'hFFC;
    kind = K_NONE;
    c    = 0;
    if (a < 'h100) begin
      if (a == 0)      kind = K_ID;
      else if (a == 4) kind = K_SCR;
      else if (a == 8) kind = K_GPIO;
    end else begin
      c   = (a - 'h100) / 'h20;
      off = (a - 'h100) % 'h20;
      if (c < NUM_CH) begin
        if (off == 0)       kind = K_TX;
        else if (off == 4)  kind = K_RX;
        else if (off == 8)  kind = K_ST;
        else if (off == 12) kind = K_CFG;
      end
      if (kind == K_NONE) c = 0;
    end
  endfunction

  task automatic model_reset();
    m_scratch = '0;
    m_gpio    = '0;
    m_wait    = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_txd[i] = '0; m_txv[i] = 0; m_cfg[i] = '0; m_blk[i] = 1;
      m_txe[i] = 0;  m_rxe[i] = 0; m_cfgwr[i] = 0;
    end
  endtask

  // Per-cycle compare against the model, then advance the model across the coming edge
  always @(negedge clk) begin : cmp
    int kind, c;
    logic e_rdy, e_err, stall;
    logic [31:0] e_rd, cur, nw;
    logic [NUM_CH-1:0] e_pop, hs;
    if (!reset_n) begin
      chk("rst_pready", pready, 0);
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_rx_ready", rx_ready, 0);
      chk("rst_cfg_wr", cfg_wr, 0);
      chk("rst_gpio", gpio_out, 0);
      chk("rst_cfg", cfg, 0);
      chk("rst_tx_data", tx_data, 0);
      model_reset();
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        chk("tx_valid", tx_valid[i], m_txv[i]);
        chk("tx_data", tx_data[i*DATA_W +: DATA_W], m_txd[i]);
        chk("cfg", cfg[i*CFG_W +: CFG_W], m_cfg[i]);
        chk("cfg_wr", cfg_wr[i], m_cfgwr[i]);
        hs[i] = m_txv[i] && tx_ready[i];
        m_cfgwr[i] = 0;
      end
      chk("gpio_out", gpio_out, m_gpio);
      if (rx_ready[0]) pop0_cnt++;
      if (cfg_wr[1]) cfgwr1_cnt++;
      e_rdy = 0; e_err = 0; e_rd = '0; e_pop = '0; stall = 0;
      if (psel && penable) begin
        decode(paddr, kind, c);
        e_rdy = 1;
        case (kind)
          K_ID:   if (pwrite) e_err = 1; else e_rd = ID_VALUE;
          K_SCR:  if (pwrite) m_scratch = bytes_merge(m_scratch, pwdata, pstrb); else e_rd = m_scratch;
          K_GPIO: begin
            if (pwrite) begin
              if (pstrb[0]) m_gpio = pwdata[7:0];
            end else e_rd = {24'h0, m_gpio};
          end
          K_TX: begin
            if (pwrite) begin
              if (!m_txv[c]) begin m_txd[c] = pwdata; m_txv[c] = 1; end
              else if (!m_blk[c] || m_wait >= TIMEOUT) begin e_err = 1; m_txe[c] = 1; end
              else stall = 1;
            end
          end
          K_RX: begin
            if (pwrite) e_err = 1;
            else if (rx_valid[c]) begin e_rd = rx_data[c*DATA_W +: DATA_W]; e_pop[c] = 1; end
            else if (!m_blk[c] || m_wait >= TIMEOUT) begin e_err = 1; m_rxe[c] = 1; end
            else stall = 1;
          end
          K_ST: begin
            if (pwrite) begin
              if (pwdata[2]) m_txe[c] = 0;
              if (pwdata[3]) m_rxe[c] = 0;
            end else e_rd = {28'h0, m_rxe[c], m_txe[c], rx_valid[c], m_txv[c]};
          end
          K_CFG: begin
            cur = {m_blk[c], 23'h0, m_cfg[c]};
            if (pwrite) begin
              nw = bytes_merge(cur, pwdata, pstrb);
              m_cfg[c] = nw[7:0]; m_blk[c] = nw[31]; m_cfgwr[c] = 1;
            end else e_rd = cur;
          end
          default: e_err = 1;
        endcase
        if (stall) e_rdy = 0;
      end
      m_wait = stall ? m_wait + 1 : 0;
      for (int i = 0; i < NUM_CH; i++) if (hs[i]) m_txv[i] = 0;
      chk("pready", pready, e_rdy);
      chk("rx_ready", rx_ready, e_pop);
      if (e_rdy) begin
        chk("pslverr", pslverr, e_err);
        if (!pwrite) chk("prdata", prdata, e_rd);
      end
    end
  end

  // Advance one clock; in random mode the stream-side inputs change every cycle
  task automatic tick();
    @(posedge clk); #1;
    if (rand_mode) begin
      tx_ready = NUM_CH'($urandom);
      rx_valid = NUM_CH'($urandom);
      rx_data  = {$urandom(), $urandom()};
    end
  endtask

  // One APB transfer; raise_at>0 raises all tx_ready after that many wait cycles
  task automatic apb(input logic wr, input logic [ADDR_W-1:0] addr, input logic [31:0] wd,
                     input logic [3:0] st, input int raise_at,
                     output logic [31:0] rd, output logic err, output int waits);
    psel = 1; penable = 0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = st;
    rd = '0; err = 0; waits = 0;
    tick();
    penable = 1;
    forever begin
      @(negedge clk);
      if (pready) begin rd = prdata; err = pslverr; break; end
      waits++;
      if (waits > TIMEOUT + 4) begin
        total++; bad++;
        $display("FAIL apb_wait: addr=%0h waited %0d cycles, limit %0d", addr, waits, TIMEOUT + 4);
        break;
      end
      tick();
      if (waits == raise_at) tx_ready = '1;
    end
    tick();
    psel = 0; penable = 0;
    $display("apb %s addr=%03h wdata=%08h strb=%h rdata=%08h err=%0d waits=%0d",
             wr ? "WR" : "RD", addr, wd, st, rd, err, waits);
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          w, p0, c1;
    logic [ADDR_W-1:0] addr_list [15];
    addr_list = '{12'h000, 12'h004, 12'h008, 12'h0F0, 12'h100, 12'h104, 12'h108, 12'h10C,
                  12'h120, 12'h124, 12'h128, 12'h12C, 12'h140, 12'h200, 12'h110};
    reset_n = 0; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; pstrb = '0;
    tx_ready = '0; rx_valid = '0; rx_data = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1;

    // Globals and reset values
    apb(0, 12'h000, 0, 4'hF, -1, rd, e, w); chk("id", rd, ID_VALUE);
    apb(0, 12'h004, 0, 4'hF, -1, rd, e, w); chk("scratch_rst", rd, 32'h0);
    apb(0, 12'h10C, 0, 4'hF, -1, rd, e, w); chk("cfg0_rst", rd, 32'h8000_0000);
    apb(1, 12'h004, 32'hA5A5_1234, 4'b0011, -1, rd, e, w);
    apb(0, 12'h004, 0, 4'hF, -1, rd, e, w); chk("scratch_strb", rd, 32'h0000_1234);

    // Ch0 TX: zero-wait first write, blocked second write released by a handshake
    apb(1, 12'h100, 32'hDEAD_BEEF, 4'hF, -1, rd, e, w);
    chk("tx1_waits", w, 0); chk("tx1_err", e, 0); chk("tx1_valid", tx_valid[0], 1);
    apb(1, 12'h100, 32'h1234_5678, 4'hF, 3, rd, e, w);
    chk("tx2_waits", w, 4); chk("tx2_err", e, 0); chk("tx2_data", tx_data[31:0], 32'h1234_5678);
    tx_ready = '0;

    // Ch1 non-blocking overflow, sticky tx_err and W1C
    apb(1, 12'h12C, 32'h0, 4'hF, -1, rd, e, w);
    apb(1, 12'h120, 32'hAAAA_0001, 4'hF, -1, rd, e, w);
    apb(1, 12'h120, 32'hBBBB_0002, 4'hF, -1, rd, e, w);
    chk("tx_ovf_err", e, 1); chk("tx_ovf_waits", w, 0); chk("tx_ovf_drop", tx_data[63:32], 32'hAAAA_0001);
    apb(0, 12'h128, 0, 4'hF, -1, rd, e, w); chk("status1_err", rd, 32'h5);
    apb(1, 12'h128, 32'h4, 4'hF, -1, rd, e, w);
    apb(0, 12'h128, 0, 4'hF, -1, rd, e, w); chk("status1_w1c", rd, 32'h1);

    // Ch0 blocking RX: timeout, then a successful pop
    p0 = pop0_cnt;
    apb(0, 12'h104, 0, 4'hF, -1, rd, e, w);
    chk("rx_to_waits", w, TIMEOUT); chk("rx_to_err", e, 1); chk("rx_to_data", rd, 0);
    chk("rx_to_nopop", pop0_cnt - p0, 0);
    apb(0, 12'h108, 0, 4'hF, -1, rd, e, w); chk("status0_rxerr", rd, 32'h9);
    rx_valid = 2'b01; rx_data = 64'h0000_0000_0000_0055;
    apb(0, 12'h104, 0, 4'hF, -1, rd, e, w);
    chk("rx_data", rd, 32'h55); chk("rx_err0", e, 0); chk("rx_pop_once", pop0_cnt - p0, 1);
    rx_valid = '0;

    // Unmapped accesses and a CFG write pulse
    apb(0, 12'h200, 0, 4'hF, -1, rd, e, w); chk("unmap_200_err", e, 1); chk("unmap_200_waits", w, 0);
    apb(1, 12'h0F0, 32'h1, 4'hF, -1, rd, e, w); chk("unmap_0f0_err", e, 1);
    c1 = cfgwr1_cnt;
    apb(1, 12'h12C, 32'h3C, 4'hF, -1, rd, e, w);
    chk("cfg1_val", cfg[15:8], 8'h3C);
    tick(); tick();
    chk("cfg_wr1_pulses", cfgwr1_cnt - c1, 1);

    // Reset during a stalled TX write
    chk("pre_rst_txv", tx_valid[0], 1);
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = 1; paddr = 12'h100; pwdata = 32'h0BAD_0BAD; pstrb = 4'hF;
    @(posedge clk); #1 penable = 1;
    repeat (3) @(posedge clk);
    @(negedge clk); chk("stall_pready", pready, 0);
    #2 reset_n = 0;
    #1 chk("async_txv", tx_valid, 0); chk("async_pready", pready, 0);
    @(posedge clk); #1 psel = 0; penable = 0;
    @(posedge clk); #1 reset_n = 1;
    apb(1, 12'h100, 32'h0000_0077, 4'hF, -1, rd, e, w);
    chk("post_rst_waits", w, 0); chk("post_rst_err", e, 0); chk("post_rst_data", tx_data[31:0], 32'h77);

    // Randomized traffic checked by the per-cycle model
    rand_mode = 1'b1;
    for (int n = 0; n < 300; n++) begin
      logic [ADDR_W-1:0] a;
      a = addr_list[$urandom_range(0, 14)] | ADDR_W'($urandom_range(0, 3));
      apb(1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom), -1, rd, e, w);
    end
    rand_mode = 1'b0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_stream_regs.md
Name: apb_stream_regs

Overview:
- Parametrised APB4 slave register block. It succeeds the fixed single-FIFO register decoder.
- Provides NUM_CH bidirectional valid/ready stream channels, each with:
  - a TX holding register;
  - an RX pop port;
  - a sticky error status;
  - a CFG register with write pulse.
- Also provides global ID, SCRATCH and GPIO registers.
- Access timing is controlled: wait states (pready low) with a timeout on full/empty, and pslverr on errors.
- Sits between the CPU APB interconnect and the USB/DAC/stream datapaths.

Parameters:
NUM_CH, 2, number of stream channels (1..8)
DATA_W, 32, stream data width (1..32); TX takes pwdata[DATA_W-1:0], RX zero-extends to 32 bits
ADDR_W, 12, APB address bits decoded
CFG_W, 8, per-channel CFG output width (1..31)
TIMEOUT, 255, maximum wait-state cycles before an error completion (1..65535)
ID_VALUE, 32'h5242_0002, constant returned by the ID register

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
psel  in  1  APB select
penable  in  1  APB enable (access phase)
paddr  in  ADDR_W  byte address; bits [1:0] ignored
pwrite  in  1  1=write
pwdata  in  32  write data
pstrb  in  4  byte strobes
prdata  out  32  read data, valid when pready=1
pready  out  1  transfer complete
pslverr  out  1  error, valid only with pready=1
gpio_out  out  8  GPIO register
tx_data  out  NUM_CH*DATA_W  per-channel TX data, channel c at [c*DATA_W +: DATA_W]
tx_valid  out  NUM_CH  TX holding register full
tx_ready  in  NUM_CH  downstream accept
rx_data  in  NUM_CH*DATA_W  per-channel RX data
rx_valid  in  NUM_CH  RX data available
rx_ready  out  NUM_CH  RX pop, one cycle per completed RX_DATA read
cfg  out  NUM_CH*CFG_W  per-channel CFG
cfg_wr  out  NUM_CH  one-cycle pulse after each CFG write

Behaviour:
Address map (word aligned):
- Global registers:
  - 0x000 ID (RO)
  - 0x004 SCRATCH (RW, 32 bits, pstrb honoured)
  - 0x008 GPIO (RW, [7:0], pstrb[0])
- Channel c base = 0x100 + c*0x20:
  - +0x0 TX_DATA (WO)
  - +0x4 RX_DATA (RO, read pops)
  - +0x8 STATUS: [0] tx_valid, [1] rx_valid, [2] tx_err, [3] rx_err; bits [3:2] are sticky and W1C
  - +0xC CFG: [CFG_W-1:0] cfg, [31] blk (1 = block with wait states); pstrb honoured
- Any other address, or channel >= NUM_CH: unmapped.

Reset (asynchronous):
- prdata=0, pready=0, pslverr=0, gpio_out=0, SCRATCH=0.
- tx_data=0, tx_valid=0, rx_ready=0, cfg=0, blk=1, cfg_wr=0, sticky errors=0, wait counter=0.
- Reset asserted mid-transfer aborts it; after release the block sits in IDLE.

APB access handling:
- pready/pslverr/prdata/rx_ready are combinational from the access phase (psel&penable), the selected channel state and the wait counter.
- Plain registers, STATUS and CFG complete in the first access cycle (zero wait).
- Unmapped address: pready=1, pslverr=1, prdata=0, no state change.
- Write to ID, RX_DATA or STATUS bits [1:0]: those bits are ignored; no error for STATUS, pslverr=1 for ID and RX_DATA.
- Read of TX_DATA: prdata=0, no error.
- CFG write: cfg updated at the completing edge; cfg_wr[c]=1 for exactly the next cycle.
- STATUS W1C: if a sticky bit sets in the same cycle as its clear, set wins.

TX_DATA write, channel c:
- tx_valid[c]=0: completes immediately. tx_data loaded, tx_valid[c]=1 at that edge. pstrb is ignored.
- tx_valid[c]=1, blk=0: immediate completion, pslverr=1, data dropped, tx_err set.
- tx_valid[c]=1, blk=1: pready=0 and the wait counter increments each cycle.
  - Completes normally in the first cycle tx_valid[c]=0.
  - A handshake in the current cycle does not count, so a handshake costs one extra wait.
  - If the counter reaches TIMEOUT: pready=1, pslverr=1, data dropped, tx_err set.
- Wait counter clears on every completion.

TX output handshake:
- tx_valid/tx_data hold stable until tx_valid&tx_ready.
- tx_valid clears at that edge.
- Back-to-back writes are limited to one per handshake.

RX_DATA read, channel c:
- rx_valid[c]=1: completes immediately, prdata = zero-extended rx_data, rx_ready[c]=1 in that same cycle only.
- rx_valid[c]=0, blk=0: immediate pslverr=1, prdata=0, rx_err set, rx_ready stays 0.
- rx_valid[c]=0, blk=1: waits until rx_valid[c]=1, then completes as above.
  - Timeout: pslverr=1, prdata=0, rx_err set.

General rules:
- rx_ready is never asserted outside a completing RX_DATA read.
- Only one transfer is in flight at a time (APB rule).
- psel dropped during a wait is a protocol violation: the counter clears and nothing is committed.

Test Plan:
- Reset, then read 0x000, 0x004, 0x10C → ID_VALUE, 0, blk bit31=1 cfg=0. Write 0x004=0xA5A5_1234 with pstrb=4'b0011, read back → 0x0000_1234.
- Ch0: write TX_DATA 0xDEAD_BEEF with tx_ready=0 → zero-wait completion, tx_valid=1. Second write stalls; raise tx_ready after 3 cycles → completes after 4 waits, no error, tx_data=0x…2nd value.
- Ch1 blk=0, tx_valid held: write TX_DATA → pslverr=1, STATUS 0x128 reads 0x5. Write 0x4 to 0x128 → reads 0x1.
- Ch0 blk=1, rx_valid=0 forever, TIMEOUT=8 → pready after 8 waits, pslverr=1, prdata=0, rx_err=1, rx_ready never high. Then rx_valid=1, rx_data=0x55 → read returns 0x55, single rx_ready pulse.
- Access 0x200 (channel 8 >= NUM_CH) and 0x0F0 → pslverr=1 immediately. Write CFG 0x12C=0x3C → cfg[15:8]=0x3C, cfg_wr[1] one-cycle pulse.
- Assert reset_n low during a stalled TX write → tx_valid, pready, wait counter 0 asynchronously. After release, the next write completes with zero wait.
